// File: rtl/fmap_stream_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fmap_stream_reader_pkg: shared types and sizing helpers              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fmap_stream_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } reader_state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fmap_stream_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fmap_stream_reader_if: element stream with valid/ready/last          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fmap_stream_reader_if #(
  parameter int BIT_WIDTH = 16
);
  logic [BIT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  modport master (output out_data, out_valid, out_last, input out_ready);
  modport slave  (input out_data, out_valid, out_last, output out_ready);
endinterface
`default_nettype wire

// File: rtl/fmap_stream_reader_lane_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fmap_stream_reader_lane_serializer: emits the valid lanes of a word  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fmap_stream_reader_lane_serializer #(
  parameter  int BIT_WIDTH = 16,
  parameter  int NUM_LANES = 2,
  localparam int CNT_W     = $clog2(NUM_LANES + 1),
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  wire logic                           clk,
  input  wire logic                           rst,
  input  wire logic                           load,
  input  wire logic [BIT_WIDTH*NUM_LANES-1:0] word,
  input  wire logic [CNT_W-1:0]               num_valid,
  output logic      [BIT_WIDTH-1:0]           data,
  output logic                                valid,
  input  wire logic                           ready,
  output logic                                word_empty
);

  logic [BIT_WIDTH*NUM_LANES-1:0] word_q;
  logic [LANE_W-1:0]              lane;
  logic [CNT_W-1:0]               lanes_q;
  logic                           valid_q;
  logic                           last_lane;

  assign last_lane = (CNT_W'(lane) + CNT_W'(1)) == lanes_q;
  assign data      = word_q[lane*BIT_WIDTH +: BIT_WIDTH];
  assign valid     = valid_q;
  // Asserted in the cycle whose handshake consumes the final lane, so the
  // controller can launch the next fetch without a bubble.
  assign word_empty = valid_q && ready && last_lane;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      lane    <= '0;
      lanes_q <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= word;
      lane    <= '0;
      lanes_q <= num_valid;
      valid_q <= 1'b1;
    end else if (valid_q && ready) begin
      if (last_lane) begin
        valid_q <= 1'b0;
        lane    <= '0;
      end else begin
        lane <= lane + LANE_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fmap_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fmap_stream_reader: streams a banked feature-map RAM element-wise    |
// | Option: FMAP_READER_RELU_EN clamps negative elements to zero         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fmap_stream_reader
  import fmap_stream_reader_pkg::*;
#(
  parameter  int OUT_X          = 42,
  parameter  int OUT_Y          = 42,
  parameter  int BIT_WIDTH      = 16,
  parameter  int NUM_RAM_SPLITS = 2,
  parameter  int RD_LATENCY     = 1,
  localparam int NUM_ELEMS      = OUT_X * OUT_Y,
  localparam int NUM_WORDS      = ceil_div(NUM_ELEMS, NUM_RAM_SPLITS),
  localparam int ADDR_W         = addr_width(NUM_WORDS)
) (
  input  wire logic                                clk,
  input  wire logic                                rst,
  input  wire logic                                start,
  output logic      [ADDR_W-1:0]                   addr_rd,
  input  wire logic [BIT_WIDTH*NUM_RAM_SPLITS-1:0] data_rd,
  fmap_stream_reader_if.master                     strm,
  output logic                                     busy,
  output logic                                     done
);

  localparam int LAST_LANES = NUM_ELEMS - (NUM_WORDS - 1) * NUM_RAM_SPLITS;
  localparam int LCNT_W     = $clog2(NUM_RAM_SPLITS + 1);
  localparam int WCNT_W     = $clog2(RD_LATENCY + 1);
  localparam int ELEM_W     = $clog2(NUM_ELEMS + 1);

  reader_state_t         state;
  reader_state_t         state_nx;
  logic [ADDR_W-1:0]     word_idx;
  logic [WCNT_W-1:0]     wait_cnt;
  logic [ELEM_W-1:0]     elem_cnt;
  logic                  load;
  logic                  last_word;
  logic                  word_empty;
  logic                  ser_valid;
  logic [BIT_WIDTH-1:0]  ser_data;
  logic [LCNT_W-1:0]     word_lanes;

  assign last_word  = word_idx == ADDR_W'(NUM_WORDS - 1);
  assign word_lanes = last_word ? LCNT_W'(LAST_LANES) : LCNT_W'(NUM_RAM_SPLITS);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_FETCH;
      ST_FETCH: state_nx = ST_WAIT;
      ST_WAIT:  if (wait_cnt == WCNT_W'(RD_LATENCY)) state_nx = ST_DRAIN;
      ST_DRAIN: if (word_empty) state_nx = last_word ? ST_DONE : ST_FETCH;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
    load = (state == ST_WAIT) && (wait_cnt == WCNT_W'(RD_LATENCY));
  end

  // The address is launched on leaving FETCH; WAIT then counts the RAM latency
  // plus one cycle so the lane buffer captures a settled word.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_idx <= '0;
      addr_rd  <= '0;
      wait_cnt <= '0;
      elem_cnt <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        word_idx <= '0;
        elem_cnt <= '0;
      end
      if (state == ST_FETCH) begin
        addr_rd  <= word_idx;
        wait_cnt <= '0;
      end
      if (state == ST_WAIT && !load) wait_cnt <= wait_cnt + WCNT_W'(1);
      if (state == ST_DRAIN && word_empty && !last_word) word_idx <= word_idx + ADDR_W'(1);
      if (ser_valid && strm.out_ready) elem_cnt <= elem_cnt + ELEM_W'(1);
    end
  end

  fmap_stream_reader_lane_serializer #(
    .BIT_WIDTH (BIT_WIDTH),
    .NUM_LANES (NUM_RAM_SPLITS)
  ) u_serializer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .word       (data_rd),
    .num_valid  (word_lanes),
    .data       (ser_data),
    .valid      (ser_valid),
    .ready      (strm.out_ready),
    .word_empty (word_empty)
  );

  assign strm.out_valid = ser_valid;
  assign strm.out_last  = ser_valid && (elem_cnt == ELEM_W'(NUM_ELEMS - 1));

`ifdef FMAP_READER_RELU_EN
  assign strm.out_data = ($signed(ser_data) < 0) ? '0 : ser_data;
`else
  assign strm.out_data = ser_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fmap_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fmap_stream_reader: scoreboard bench, random RAM and backpressure |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fmap_stream_reader;

  localparam int OX  = 7;
  localparam int OY  = 2;
  localparam int BW  = 16;
  localparam int S   = 3;
  localparam int RDL = 2;
  localparam int NE  = OX * OY;
  localparam int NW  = (NE + S - 1) / S;
  localparam int AW  = (NW > 1) ? $clog2(NW) : 1;

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            start;
  logic [AW-1:0]   addr_rd;
  logic [BW*S-1:0] data_rd;
  logic            busy;
  logic            done;

  fmap_stream_reader_if #(.BIT_WIDTH(BW)) strm ();

  fmap_stream_reader #(
    .OUT_X          (OX),
    .OUT_Y          (OY),
    .BIT_WIDTH      (BW),
    .NUM_RAM_SPLITS (S),
    .RD_LATENCY     (RDL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr_rd (addr_rd),
    .data_rd (data_rd),
    .strm    (strm),
    .busy    (busy),
    .done    (done)
  );

  logic [BW*S-1:0] mem [NW];
  logic [AW-1:0]   rd_pipe [RDL];
  exp_t            sb [$];
  int              n_checks = 0;
  int              n_pass   = 0;
  int              ready_mode = 0;
  int              max_addr = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM with RDL cycles from address to data
  always @(posedge clk) begin
    rd_pipe[0] <= addr_rd;
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign data_rd = mem[rd_pipe[RDL-1]];

  always @(negedge clk) if (int'(addr_rd) > max_addr) max_addr = int'(addr_rd);

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  function automatic logic [BW-1:0] model_elem(input logic [BW-1:0] e);
`ifdef FMAP_READER_RELU_EN
    return ($signed(e) < 0) ? '0 : e;
`else
    return e;
`endif
  endfunction

  // 1,0,0,1 pattern, random, or held low
  initial begin
    int ph;
    ph = 0;
    strm.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       strm.out_ready = 1'b1;
        1:       begin strm.out_ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
        2:       strm.out_ready = 1'($urandom_range(0, 1));
        default: strm.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and tracks done timing
  initial begin
    exp_t          e;
    bit            stalled;
    logic [BW-1:0] st_data;
    logic          st_last;
    int            done_chk;
    stalled  = 0;
    done_chk = 0;
    st_data  = '0;
    st_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (done_chk == 1) begin
        check("done_pulse", done == 1'b1, done, 1);
        done_chk = 2;
      end else if (done_chk == 2) begin
        check("done_single_busy_low", done == 1'b0 && busy == 1'b0, {done, busy}, 0);
        done_chk = 0;
      end else if (done) begin
        check("unexpected_done", done == 1'b0, done, 0);
      end
      if (rst) begin
        stalled = 0;
      end else begin
        if (stalled)
          check("stall_stable", strm.out_valid && strm.out_data == st_data && strm.out_last == st_last,
                {strm.out_valid, strm.out_last, strm.out_data}, {1'b1, st_last, st_data});
        if (strm.out_valid && strm.out_ready) begin
          stalled = 0;
          if (sb.size() == 0) begin
            check("unexpected_elem", 1'b0, strm.out_data, 0);
          end else begin
            e = sb.pop_front();
            check("elem_data", strm.out_data == e.data, strm.out_data, e.data);
            check("elem_last", strm.out_last == e.last, strm.out_last, e.last);
            if (e.last) done_chk = 1;
          end
        end else if (strm.out_valid) begin
          stalled = 1;
          st_data = strm.out_data;
          st_last = strm.out_last;
        end else begin
          stalled = 0;
        end
      end
    end
  end

  task automatic fill_mem(input bit special);
    for (int w = 0; w < NW; w++)
      for (int l = 0; l < S; l++) mem[w][l*BW +: BW] = BW'($urandom());
    if (special) begin
      mem[0][0 +: BW]  = 16'h8001;
      mem[0][BW +: BW] = 16'h0005;
    end
  endtask

  task automatic push_expected();
    logic [BW*S-1:0] w;
    exp_t            e;
    for (int k = 0; k < NE; k++) begin
      w = mem[k / S];
      e.data = model_elem(w[(k % S)*BW +: BW]);
      e.last = (k == NE - 1);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input int mode, input bit mid_start, input bit done_start);
    int lat;
    bit got;
    ready_mode = mode;
    push_expected();
    max_addr = 0;
    pulse_start();
    lat = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (strm.out_valid) begin lat = c; break; end
      @(posedge clk);
    end
    check("first_valid_latency", lat == RDL + 2, lat, RDL + 2);
    if (mid_start) begin
      repeat (3) @(posedge clk);
      pulse_start();
    end
    got = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    check("done_seen", got, got, 1);
    if (done_start && got) begin
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    repeat (4) @(negedge clk);
    check("idle_after", busy == 1'b0 && strm.out_valid == 1'b0, {busy, strm.out_valid}, 0);
    check("queue_drained", sb.size() == 0, sb.size(), 0);
    check("max_addr", max_addr == NW - 1, max_addr, NW - 1);
  endtask

  task automatic reset_abort();
    int  cnt;
    bit  any_done;
    ready_mode = 0;
    push_expected();
    pulse_start();
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (strm.out_valid && strm.out_ready) cnt++;
      if (cnt == 2) break;
    end
    check("abort_reached_elem2", cnt == 2, cnt, 2);
    ready_mode = 3;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_valid", strm.out_valid == 1'b0, strm.out_valid, 0);
    check("abort_busy", busy == 1'b0, busy, 0);
    check("abort_addr", addr_rd == '0, addr_rd, 0);
    check("abort_done", done == 1'b0, done, 0);
    sb.delete();
    ready_mode = 0;
    any_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || strm.out_valid) any_done = 1;
    end
    check("abort_stays_idle", any_done == 1'b0, any_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill_mem(1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_addr", addr_rd == '0, addr_rd, 0);
    check("rst_valid", strm.out_valid == 1'b0, strm.out_valid, 0);
    check("rst_last", strm.out_last == 1'b0, strm.out_last, 0);
    check("rst_data", strm.out_data == '0, strm.out_data, 0);
    check("rst_busy", busy == 1'b0, busy, 0);
    check("rst_done", done == 1'b0, done, 0);

    run(0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0);
    run(0, 1'b0, 1'b0);
    fill_mem(1'b0);
    run(2, 1'b1, 1'b1);
    run(2, 1'b0, 1'b0);
    reset_abort();
    fill_mem(1'b0);
    run(2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
